can_bit_timing: RTL and testbench

- Programmable CAN bit-timing unit: successor to the fixed-rate baud generator inside the CAN peripheral harness.
- Generates time quanta from a register-set prescaler and sequences SYNC/SEG1/SEG2 per bit.
- Performs hard sync and SJW-limited resynchronisation on recessive-to-dominant edges.
- Emits sample and transmit points for the CAN MAC; configured over the TinyQV peripheral register bus.

---
 rtl/can_pkg.sv | 24 ++
 rtl/can_tq_prescaler.sv | 27 ++
 rtl/can_bit_timing.sv | 223 ++++++++++++++++++++++
 tb/tb_can_bit_timing.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared types, register map and reset defaults for the CAN bit-timing unit
package can_pkg;

    typedef enum logic [1:0] {
        SEG_SYNC = 2'd0,
        SEG_1    = 2'd1,
        SEG_2    = 2'd2
    } seg_state_e;

    localparam logic [3:0] ADDR_BRP    = 4'h0;
    localparam logic [3:0] ADDR_SEG    = 4'h1;
    localparam logic [3:0] ADDR_CTRL   = 4'h2;
    localparam logic [3:0] ADDR_STATUS = 4'h3;

    localparam int CAN_DEF_BRP   = 7;
    localparam int CAN_DEF_TSEG1 = 12;
    localparam int CAN_DEF_TSEG2 = 1;
    localparam int CAN_DEF_SJW   = 1;

    function automatic logic [5:0] min6(input logic [5:0] a, input logic [5:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/can_tq_prescaler.sv
// rtl/can_tq_prescaler.sv - time-quantum prescaler, one tq_tick every brp+1 clocks
module can_tq_prescaler #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clear,
    input  logic [W-1:0] brp,
    output logic         tq_tick
);

    logic [W-1:0] cnt;

    assign tq_tick = en & ~clear & (cnt == brp);

    always_ff @(posedge clk) begin
        if (rst || clear || !en) begin
            cnt <= '0;
        end else if (tq_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/can_bit_timing.sv
// rtl/can_bit_timing.sv - programmable CAN bit timing: tq generation, SYNC/SEG1/SEG2 sequencing, hard sync and resync
module can_bit_timing
    import can_pkg::*;
#(
    parameter int BRP_W     = 8,
    parameter int DEF_BRP   = CAN_DEF_BRP,
    parameter int DEF_TSEG1 = CAN_DEF_TSEG1,
    parameter int DEF_TSEG2 = CAN_DEF_TSEG2,
    parameter int DEF_SJW   = CAN_DEF_SJW
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_write,
    input  logic [3:0] address,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic       rx_in,
    input  logic       tx_bit,
    input  logic       hard_sync_en,
    input  logic       resync_en,
    output logic       tq_tick,
    output logic       sample_tick,
    output logic       sampled_bit,
    output logic       tx_point,
    output logic       can_tx
);

    logic [BRP_W-1:0] brp_q, brp_n, sh_brp;
    logic [3:0]       tseg1_q, tseg1_n, sh_tseg1;
    logic [2:0]       tseg2_q, tseg2_n, sh_tseg2;
    logic [1:0]       sjw_q, sjw_n, sh_sjw;
    logic             en_q, en_n;

    seg_state_e state_q, state_d;
    logic [4:0] k_q, k_d;
    logic [2:0] ext_q, ext_d, shr_q, shr_d;
    logic       rs_done_q, rs_done_d;
    logic       prev_rx, sbit_q, ctx_q, hsync_q;
    logic       fall_edge, hs, enter_sync;
    logic [5:0] k6, sjw1, ext_v, shr_v;

    // Register values as they will be after this clock; shadows load from here
    // so a write coinciding with SYNC entry lands in the new bit.
    always_comb begin
        brp_n   = brp_q;
        tseg1_n = tseg1_q;
        tseg2_n = tseg2_q;
        sjw_n   = sjw_q;
        en_n    = en_q;
        if (data_write) begin
            case (address)
                ADDR_BRP:  brp_n = BRP_W'(data_in);
                ADDR_SEG: begin
                    tseg1_n = data_in[3:0];
                    tseg2_n = data_in[6:4];
                end
                ADDR_CTRL: begin
                    sjw_n = data_in[1:0];
                    en_n  = data_in[7];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (address)
            ADDR_BRP:    data_out = 8'(brp_q);
            ADDR_SEG:    data_out = {1'b0, tseg2_q, tseg1_q};
            ADDR_CTRL:   data_out = {en_q, 5'b0, sjw_q};
            ADDR_STATUS: data_out = {4'b0, state_q, hsync_q, sbit_q};
            default:     data_out = 8'h00;
        endcase
    end

    can_tq_prescaler #(.W(BRP_W)) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .en      (en_q),
        .clear   (~en_q),
        .brp     (sh_brp),
        .tq_tick (tq_tick)
    );

    assign fall_edge   = prev_rx & ~rx_in;
    assign k6          = {1'b0, k_q};
    assign sjw1        = {4'b0, sh_sjw} + 6'd1;
    assign sampled_bit = sbit_q;
    assign can_tx      = ctx_q | ~en_q;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        ext_d       = ext_q;
        shr_d       = shr_q;
        rs_done_d   = rs_done_q;
        ext_v       = {3'b0, ext_q};
        shr_v       = {3'b0, shr_q};
        hs          = 1'b0;
        sample_tick = 1'b0;
        tx_point    = 1'b0;
        enter_sync  = 1'b0;
        if (tq_tick) begin
            if (hard_sync_en && fall_edge) begin
                hs      = 1'b1;
                state_d = SEG_1;
                k_d     = '0;
                ext_d   = '0;
                shr_d   = '0;
            end else begin
                case (state_q)
                    SEG_SYNC: begin
                        state_d = SEG_1;
                        k_d     = '0;
                    end
                    SEG_1: begin
                        if (resync_en && fall_edge && !rs_done_q) begin
                            ext_v     = min6(k6 + 6'd1, sjw1);
                            rs_done_d = 1'b1;
                        end
                        ext_d = ext_v[2:0];
                        if (k6 >= {2'b0, sh_tseg1} + ext_v) begin
                            sample_tick = 1'b1;
                            rs_done_d   = 1'b0;
                            state_d     = SEG_2;
                            k_d         = '0;
                        end else begin
                            k_d = k_q + 5'd1;
                        end
                    end
                    SEG_2: begin
                        // Phase error is the number of SEG2 quanta still to run, this one included.
                        if (resync_en && fall_edge && !rs_done_q) begin
                            shr_v     = min6({3'b0, sh_tseg2} + 6'd1 - k6, sjw1);
                            rs_done_d = 1'b1;
                        end
                        shr_d = shr_v[2:0];
                        if (k6 + 6'd1 >= {3'b0, sh_tseg2} + 6'd1 - shr_v) begin
                            enter_sync = 1'b1;
                            tx_point   = 1'b1;
                            state_d    = SEG_SYNC;
                            k_d        = '0;
                            ext_d      = '0;
                            shr_d      = '0;
                        end else begin
                            k_d = k_q + 5'd1;
                        end
                    end
                    default: begin
                        state_d = SEG_SYNC;
                        k_d     = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            brp_q     <= BRP_W'(DEF_BRP);
            tseg1_q   <= 4'(DEF_TSEG1);
            tseg2_q   <= 3'(DEF_TSEG2);
            sjw_q     <= 2'(DEF_SJW);
            en_q      <= 1'b0;
            sh_brp    <= BRP_W'(DEF_BRP);
            sh_tseg1  <= 4'(DEF_TSEG1);
            sh_tseg2  <= 3'(DEF_TSEG2);
            sh_sjw    <= 2'(DEF_SJW);
            state_q   <= SEG_SYNC;
            k_q       <= '0;
            ext_q     <= '0;
            shr_q     <= '0;
            rs_done_q <= 1'b0;
            prev_rx   <= 1'b1;
            sbit_q    <= 1'b1;
            ctx_q     <= 1'b1;
            hsync_q   <= 1'b0;
        end else begin
            brp_q   <= brp_n;
            tseg1_q <= tseg1_n;
            tseg2_q <= tseg2_n;
            sjw_q   <= sjw_n;
            en_q    <= en_n;
            if (hs) begin
                hsync_q <= 1'b1;
            end else if (data_write && address == ADDR_STATUS) begin
                hsync_q <= 1'b0;
            end
            if (!en_q) begin
                state_q   <= SEG_SYNC;
                k_q       <= '0;
                ext_q     <= '0;
                shr_q     <= '0;
                rs_done_q <= 1'b0;
                ctx_q     <= 1'b1;
                sh_brp    <= brp_n;
                sh_tseg1  <= tseg1_n;
                sh_tseg2  <= tseg2_n;
                sh_sjw    <= sjw_n;
            end else begin
                state_q   <= state_d;
                k_q       <= k_d;
                ext_q     <= ext_d;
                shr_q     <= shr_d;
                rs_done_q <= rs_done_d;
                if (tq_tick) begin
                    prev_rx <= rx_in;
                end
                if (sample_tick) begin
                    sbit_q <= rx_in;
                end
                if (enter_sync) begin
                    ctx_q    <= tx_bit;
                    sh_brp   <= brp_n;
                    sh_tseg1 <= tseg1_n;
                    sh_tseg2 <= tseg2_n;
                    sh_sjw   <= sjw_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_can_bit_timing.sv
// tb/tb_can_bit_timing.sv - randomized self-checking bench against a bit-position reference model
module tb_can_bit_timing;

    logic       clk = 1'b0;
    logic       rst, data_write, rx_in, tx_bit, hard_sync_en, resync_en;
    logic [3:0] address;
    logic [7:0] data_in, data_out;
    logic       tq_tick, sample_tick, sampled_bit, tx_point, can_tx;

    always #5 clk = ~clk;

    can_bit_timing dut (
        .clk          (clk),
        .rst          (rst),
        .data_write   (data_write),
        .address      (address),
        .data_in      (data_in),
        .data_out     (data_out),
        .rx_in        (rx_in),
        .tx_bit       (tx_bit),
        .hard_sync_en (hard_sync_en),
        .resync_en    (resync_en),
        .tq_tick      (tq_tick),
        .sample_tick  (sample_tick),
        .sampled_bit  (sampled_bit),
        .tx_point     (tx_point),
        .can_tx       (can_tx)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: bit described by absolute tq positions (0 = SYNC quantum).
    int m_brp, m_tseg1, m_tseg2, m_sjw, m_en;
    int s_brp, s_tseg1, s_tseg2, s_sjw;
    int pc, t, samp_at, shr, rs_done, prev_rx, sbit, ctx, hsync;

    function automatic int mmin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_brp = 7; m_tseg1 = 12; m_tseg2 = 1; m_sjw = 1; m_en = 0;
        s_brp = 7; s_tseg1 = 12; s_tseg2 = 1; s_sjw = 1;
        pc = 0; t = 0; samp_at = 13; shr = 0; rs_done = 0;
        prev_rx = 1; sbit = 1; ctx = 1; hsync = 0;
    endtask

    function automatic int mseg();
        if (t == 0) return 0;
        if (t <= samp_at) return 1;
        return 2;
    endfunction

    function automatic int exp_dout(input int a);
        case (a)
            0: return m_brp;
            1: return (m_tseg2 << 4) | m_tseg1;
            2: return (m_en << 7) | m_sjw;
            3: return (mseg() << 2) | (hsync << 1) | sbit;
            default: return 0;
        endcase
    endfunction

    task automatic model_step(output int e_tq, output int e_samp, output int e_tx);
        int n_brp, n_tseg1, n_tseg2, n_sjw, n_en, tick, fall, hs, len;
        n_brp = m_brp; n_tseg1 = m_tseg1; n_tseg2 = m_tseg2; n_sjw = m_sjw; n_en = m_en;
        if (data_write) begin
            case (address)
                4'd0: n_brp = data_in;
                4'd1: begin n_tseg1 = data_in & 15; n_tseg2 = (data_in >> 4) & 7; end
                4'd2: begin n_sjw = data_in & 3; n_en = data_in[7]; end
                default: ;
            endcase
        end
        tick = (m_en != 0 && pc == s_brp) ? 1 : 0;
        e_tq = tick; e_samp = 0; e_tx = 0; hs = 0;
        if (m_en == 0) begin
            pc = 0; t = 0; shr = 0; rs_done = 0; ctx = 1;
            s_brp = n_brp; s_tseg1 = n_tseg1; s_tseg2 = n_tseg2; s_sjw = n_sjw;
            samp_at = n_tseg1 + 1;
        end else begin
            pc = tick ? 0 : pc + 1;
            if (tick) begin
                fall = (prev_rx == 1 && rx_in == 0) ? 1 : 0;
                prev_rx = rx_in;
                if (hard_sync_en && fall) begin
                    hs = 1; hsync = 1; t = 1; samp_at = s_tseg1 + 1; shr = 0;
                end else if (t == 0) begin
                    t = 1;
                end else if (t <= samp_at) begin
                    if (resync_en && fall && !rs_done) begin
                        samp_at += mmin(t, s_sjw + 1);
                        rs_done = 1;
                    end
                    if (t == samp_at) begin
                        e_samp = 1; sbit = rx_in; rs_done = 0;
                    end
                    t++;
                end else begin
                    len = samp_at + s_tseg2 + 2 - shr;
                    if (resync_en && fall && !rs_done) begin
                        shr = mmin(len - t, s_sjw + 1);
                        rs_done = 1;
                        len = samp_at + s_tseg2 + 2 - shr;
                    end
                    if (t + 1 >= len) begin
                        e_tx = 1; ctx = tx_bit; t = 0; shr = 0;
                        s_brp = n_brp; s_tseg1 = n_tseg1; s_tseg2 = n_tseg2; s_sjw = n_sjw;
                        samp_at = n_tseg1 + 1;
                    end else begin
                        t++;
                    end
                end
            end
        end
        if (data_write && address == 4'd3 && !hs) hsync = 0;
        m_brp = n_brp; m_tseg1 = n_tseg1; m_tseg2 = n_tseg2; m_sjw = n_sjw; m_en = n_en;
        if (rst) model_reset();
    endtask

    int cyc = 0;
    int last_tx, last_tq, tx_period, samp_gap, tq_period;

    task automatic clear_meas();
        last_tx = -1; last_tq = -1; tx_period = -1; samp_gap = -1; tq_period = -1;
    endtask

    // Called with inputs applied just after a negedge; returns at the next negedge.
    task automatic step();
        int e_tq, e_samp, e_tx;
        #1;
        chk("data_out", data_out, exp_dout(address));
        chk("sampled_bit", sampled_bit, sbit);
        chk("can_tx", can_tx, (ctx != 0 || m_en == 0) ? 1 : 0);
        model_step(e_tq, e_samp, e_tx);
        chk("tq_tick", tq_tick, e_tq);
        chk("sample_tick", sample_tick, e_samp);
        chk("tx_point", tx_point, e_tx);
        if (tq_tick) begin
            if (last_tq >= 0) tq_period = cyc - last_tq;
            last_tq = cyc;
        end
        if (tx_point) begin
            if (last_tx >= 0) tx_period = cyc - last_tx;
            last_tx = cyc;
        end
        if (sample_tick && last_tx >= 0) samp_gap = cyc - last_tx;
        cyc++;
        @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        data_write = 1'b1; address = a; data_in = d;
        step();
        data_write = 1'b0;
    endtask

    initial begin
        int hs_mode;
        rst = 1'b1; data_write = 1'b0; address = 4'd0; data_in = 8'd0;
        rx_in = 1'b1; tx_bit = 1'b1; hard_sync_en = 1'b0; resync_en = 1'b0;
        clear_meas();
        repeat (2) @(negedge clk);
        model_reset();
        rst = 1'b0;
        for (int a = 0; a < 4; a++) begin
            address = 4'(a);
            #1;
            case (a)
                0: chk("rst_brp", data_out, 7);
                1: chk("rst_seg", data_out, 8'h1C);
                2: chk("rst_ctrl", data_out, 1);
                default: chk("rst_status", data_out, 1);
            endcase
        end
        chk("rst_tq_tick", tq_tick, 0);
        chk("rst_can_tx", can_tx, 1);
        chk("rst_sampled_bit", sampled_bit, 1);
        address = 4'd0;
        @(negedge clk);

        // Default timing: 8-clk tq, 16-tq bit, sample 14 tq after bit start.
        wr(4'd2, 8'h81);
        clear_meas();
        repeat (420) step();
        chk("def_tq_period", tq_period, 8);
        chk("def_bit_period", tx_period, 128);
        chk("def_tx_to_sample", samp_gap, 112);

        // Fast bit: BRP=0, TSEG1=2, TSEG2=1 -> 6 clk per bit.
        wr(4'd0, 8'd0);
        wr(4'd1, 8'h12);
        repeat (200) step();
        clear_meas();
        for (int i = 0; i < 60; i++) begin
            tx_bit = 1'($urandom);
            step();
        end
        chk("fast_tq_period", tq_period, 1);
        chk("fast_bit_period", tx_period, 6);
        chk("fast_tx_to_sample", samp_gap, 4);

        // Reset in the middle of a bit.
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        address = 4'd0;
        #1;
        chk("midrst_brp", data_out, 7);
        chk("midrst_tq_tick", tq_tick, 0);
        chk("midrst_tx_point", tx_point, 0);
        chk("midrst_can_tx", can_tx, 1);
        chk("midrst_sampled_bit", sampled_bit, 1);

        for (int blk = 0; blk < 30; blk++) begin
            wr(4'd0, 8'($urandom_range(0, 3)));
            wr(4'd1, 8'($urandom & 8'h7F));
            wr(4'd2, 8'h80 | 8'($urandom_range(0, 3)));
            hs_mode = $urandom_range(0, 2);
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 11) == 0) rx_in = ~rx_in;
                tx_bit       = 1'($urandom);
                hard_sync_en = (hs_mode == 2) || (hs_mode == 1 && $urandom_range(0, 7) == 0);
                resync_en    = ($urandom_range(0, 7) != 0);
                address      = 4'($urandom_range(0, 15));
                data_write   = ($urandom_range(0, 79) == 0);
                rst          = ($urandom_range(0, 2999) == 0);
                data_in      = 8'($urandom);
                if (data_write && address == 4'd0) data_in = data_in & 8'h03;
                if (data_write && address == 4'd2)
                    data_in = ($urandom_range(0, 9) != 0) ? (data_in | 8'h80) : (data_in & 8'h7F);
                step();
            end
            data_write = 1'b0;
            rst = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
